axil_sdram_bridge: RTL

//  AXI4-Lite slave that turns 32-bit register-style accesses into sequenced 16-bit host

---
 rtl/axil_sdram_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axil_sdram_bridge.sv
// axil_sdram_bridge: AXI4-Lite slave that splits each 32-bit access into two 16-bit sdram_controller commands
module axil_sdram_bridge #(
  parameter int HADDR_WIDTH    = 24,
  parameter int AXI_ADDR_WIDTH = HADDR_WIDTH + 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [HADDR_WIDTH-1:0]    wr_addr,
  output logic [15:0]               wr_data,
  output logic                      wr_enable,
  output logic [HADDR_WIDTH-1:0]    rd_addr,
  output logic                      rd_enable,
  input  logic [15:0]               rd_data,
  input  logic                      rd_ready,
  input  logic                      busy
);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, WR_RESP, RD_RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic h, h_n, pri, got, hi_pend;
  logic [CW-1:0] cnt;
  logic [HADDR_WIDTH-2:0] addr;
  logic [31:0] wd, rbuf;
  logic [1:0] resp;
  logic take_wr, take_rd, mixed, lo_in, hi_in, expired, rd_cap, unused;
  // pri=0 favours the write when both requests are pending
  assign take_wr = (state == IDLE) & s_axi_awvalid & s_axi_wvalid & (~s_axi_arvalid | ~pri);
  assign take_rd = (state == IDLE) & s_axi_arvalid & ~take_wr;
  assign mixed   = (s_axi_wstrb[0] ^ s_axi_wstrb[1]) | (s_axi_wstrb[2] ^ s_axi_wstrb[3]);
  assign lo_in   = &s_axi_wstrb[1:0];
  assign hi_in   = &s_axi_wstrb[3:2];
  assign expired = cnt == CW'(TIMEOUT_CYCLES);
  assign rd_cap  = rd_ready & ~got & (state == RD_ISSUE | state == RD_WAIT);
  assign unused  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  always_comb begin
    state_n = state;
    h_n = h;
    case (state)
      IDLE: if (take_wr) begin
          state_n = (mixed | ~(lo_in | hi_in)) ? WR_RESP : WR_ISSUE;
          h_n = ~lo_in;
        end else if (take_rd) begin
          state_n = RD_ISSUE;
          h_n = 1'b0;
        end
      WR_ISSUE: state_n = expired ? WR_RESP : busy ? WR_WAIT : WR_ISSUE;
      WR_WAIT: if (expired) state_n = WR_RESP;
        else if (!busy) begin
          state_n = (~h & hi_pend) ? WR_ISSUE : WR_RESP;
          h_n = 1'b1;
        end
      RD_ISSUE: state_n = expired ? RD_RESP : busy ? RD_WAIT : RD_ISSUE;
      RD_WAIT: if (expired) state_n = RD_RESP;
        else if (!busy && got) begin
          state_n = h ? RD_RESP : RD_ISSUE;
          h_n = 1'b1;
        end
      WR_RESP: state_n = s_axi_bready ? IDLE : WR_RESP;
      RD_RESP: state_n = s_axi_rready ? IDLE : RD_RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      h <= 1'b0;
      pri <= 1'b0;
      got <= 1'b0;
      hi_pend <= 1'b0;
      cnt <= '0;
      addr <= '0;
      wd <= '0;
      rbuf <= '0;
      resp <= 2'b00;
    end else begin
      state <= state_n;
      h <= h_n;
      cnt <= (state_n != state) ? '0 : cnt + 1'b1;
      got <= (state == RD_WAIT && state_n != RD_WAIT) ? 1'b0 : (got | rd_cap) & (state_n == RD_ISSUE || state_n == RD_WAIT);
      if (rd_cap) begin
        if (h) rbuf[31:16] <= rd_data;
        else rbuf[15:0] <= rd_data;
      end
      if (take_wr) begin
        addr <= s_axi_awaddr[HADDR_WIDTH:2];
        wd <= s_axi_wdata;
        hi_pend <= hi_in;
        resp <= mixed ? 2'b10 : 2'b00;
      end
      if (take_rd) begin
        addr <= s_axi_araddr[HADDR_WIDTH:2];
        rbuf <= '0;
        resp <= 2'b00;
      end
      if (expired && state inside {WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT}) resp <= 2'b10;
      if ((state == WR_RESP && s_axi_bready) || (state == RD_RESP && s_axi_rready)) pri <= ~pri;
    end
  assign s_axi_awready = take_wr;
  assign s_axi_wready  = take_wr;
  assign s_axi_arready = take_rd;
  assign s_axi_bvalid  = state == WR_RESP;
  assign s_axi_rvalid  = state == RD_RESP;
  assign s_axi_bresp   = resp;
  assign s_axi_rresp   = resp;
  assign s_axi_rdata   = rbuf;
  assign wr_enable     = state == WR_ISSUE;
  assign rd_enable     = state == RD_ISSUE;
  assign wr_addr       = {addr, h};
  assign rd_addr       = {addr, h};
  assign wr_data       = h ? wd[31:16] : wd[15:0];
endmodule
